// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings and byte-lane helper for the memory slave and its masters.
package ahb_lite_pkg;

    typedef enum logic [1:0] {
        TransIdle   = 2'b00,
        TransBusy   = 2'b01,
        TransNonseq = 2'b10,
        TransSeq    = 2'b11
    } htrans_e;

    typedef enum logic [1:0] {
        Size8    = 2'b00,
        Size16   = 2'b01,
        Size32   = 2'b10,
        SizeRsvd = 2'b11
    } hsize_e;

    typedef enum logic [1:0] {
        RespOkay  = 2'b00,
        RespError = 2'b01,
        RespRetry = 2'b10,
        RespSplit = 2'b11
    } hresp_e;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StErr1,
        StErr2
    } slv_state_e;

    // Little-endian lane enables for a transfer of the given size at offset addr[1:0].
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] addr);
        logic [3:0] m;
        m = 4'b0000;
        case (size)
            Size8:   m = 4'b0001 << addr;
            Size16:  m = addr[1] ? 4'b1100 : 4'b0011;
            Size32:  m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ahb_lite_mem_slave_if.sv
// AHB-Lite slave-side bus bundle; clock and reset are carried as plain ports.
interface ahb_lite_mem_slave_if;

    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [1:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADYin;
    logic        HREADYOUT;
    logic [1:0]  HRESP;
    logic [31:0] HRDATA;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADYin,
        input  HREADYOUT, HRESP, HRDATA
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADYin,
        output HREADYOUT, HRESP, HRDATA
    );

endinterface

// File: rtl/ahb_lite_bytelane_ram.sv
// Word-organised array with per-byte write enables and asynchronous read.
module ahb_lite_bytelane_ram #(
    parameter int unsigned ADDR_W = 6
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [3:0]        i_be,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_wdata,
    output logic [31:0]       o_rdata
);

    logic [31:0] r_mem [2**ADDR_W];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int b = 0; b < 4; b++) begin
                if (i_be[b]) begin
                    r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/ahb_lite_mem_slave.sv
// AHB-Lite memory slave: address decode, wait-state insertion, two-cycle ERROR and byte-lane RAM.
module ahb_lite_mem_slave
    import ahb_lite_pkg::*;
#(
    parameter int unsigned ADDR_W      = 6,
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [31:0] SLV_ID      = 32'h5A5A_0001
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    ahb_lite_mem_slave_if.slave  bus
);

    slv_state_e        r_state;
    slv_state_e        w_state_d;
    logic [3:0]        r_cnt;
    logic [3:0]        w_cnt_d;
    logic [ADDR_W+1:0] r_addr;
    logic              r_write;
    logic [1:0]        r_size;

    logic              w_ready;
    hresp_e            w_resp;
    logic              w_final;
    logic              w_accept;
    logic              w_err;
    logic              w_we;
    logic [31:0]       w_ram_rdata;
    logic              w_unused;

    assign w_unused = ^{bus.HADDR[31:ADDR_W+2], bus.HTRANS[0]};

    always_comb begin
        w_ready = 1'b1;
        w_resp  = RespOkay;
        case (r_state)
            StWait:  w_ready = (r_cnt == 4'd0);
            StErr1: begin
                w_ready = 1'b0;
                w_resp  = RespError;
            end
            StErr2:  w_resp = RespError;
            default: w_ready = 1'b1;
        endcase
    end

    assign w_final  = (r_state == StWait) && (r_cnt == 4'd0);
    assign w_accept = w_ready & bus.HSEL & bus.HTRANS[1] & bus.HREADYin;

    assign w_err = (bus.HSIZE == SizeRsvd)
                 | ((bus.HSIZE == Size16) & bus.HADDR[0])
                 | ((bus.HSIZE == Size32) & (bus.HADDR[1:0] != 2'b00))
                 | (bus.HWRITE & (bus.HADDR[ADDR_W+1:2] == '0));

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        case (r_state)
            StIdle: w_state_d = StIdle;
            StWait: begin
                if (r_cnt != 4'd0) begin
                    w_cnt_d = r_cnt - 4'd1;
                end else begin
                    w_state_d = StIdle;
                end
            end
            StErr1:  w_state_d = StErr2;
            StErr2:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
        // Accept is only possible in a ready cycle, so it overrides the fall back to IDLE.
        if (w_accept) begin
            w_state_d = w_err ? StErr1 : StWait;
            w_cnt_d   = 4'(WAIT_STATES);
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state <= StIdle;
            r_cnt   <= 4'd0;
            r_addr  <= '0;
            r_write <= 1'b0;
            r_size  <= 2'b00;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            if (w_accept) begin
                r_addr  <= bus.HADDR[ADDR_W+1:0];
                r_write <= bus.HWRITE;
                r_size  <= bus.HSIZE;
            end
        end
    end

    assign w_we = w_final & r_write;

    ahb_lite_bytelane_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .i_clk   (HCLK),
        .i_we    (w_we),
        .i_be    (lane_mask(r_size, r_addr[1:0])),
        .i_addr  (r_addr[ADDR_W+1:2]),
        .i_wdata (bus.HWDATA),
        .o_rdata (w_ram_rdata)
    );

    assign bus.HREADYOUT = w_ready;
    assign bus.HRESP     = w_resp;
    assign bus.HRDATA    = (w_final & ~r_write)
                         ? ((r_addr[ADDR_W+1:2] == '0) ? SLV_ID : w_ram_rdata)
                         : 32'h0;

endmodule
